// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic controller: lamp bit positions, sensor
// channel indices and the per-channel request state.
package traffic_pkg;

    localparam int RED    = 4;
    localparam int YEL    = 3;
    localparam int GRN    = 2;
    localparam int YARROW = 1;
    localparam int GARROW = 0;

    localparam int LEFT_MAIN     = 0;
    localparam int LEFT_CROSS    = 1;
    localparam int CROSS_TRAFFIC = 2;
    localparam int WALK_MAIN     = 3;
    localparam int WALK_CROSS    = 4;
    localparam int NUM_CH        = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVED  = 2'd2
    } ch_state_e;

    function automatic logic [2:0] popcount5(input logic [4:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 5; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One raw button: 2-flop synchroniser, hold-time debouncer and a registered
// one-cycle press pulse on each accepted rising level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             stable_d_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchroniser, debounce counter and press edge detector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            stable_r   <= 1'b0;
            stable_d_r <= 1'b0;
            press_r    <= 1'b0;
            cnt_r      <= CNT_ZERO;
        end else begin
            sync1_r    <= button;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            press_r    <= stable_r & ~stable_d_r;
            if (sync2_r == stable_r) begin
                cnt_r <= CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
                stable_r <= sync2_r;
                cnt_r    <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/traffic_request_latch.sv
// Latches debounced button presses as pending requests for the light FSM and
// clears each one when the lamp that serves it comes on.
module traffic_request_latch
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] buttons,
    input  logic [4:0] main_lights,
    input  logic [4:0] cross_lights,
    output logic [4:0] sensors,
    output logic [2:0] pending_count
);

    logic [4:0] press_s;
    logic [4:0] srv_s;
    logic [4:0] pend_next_s;
    logic [4:0] sensors_r;
    logic [2:0] pending_count_r;
    logic       unused_lights_s;
    ch_state_e  state_r      [NUM_CH];
    ch_state_e  state_next_s [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_deb
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .button(buttons[g]),
            .press (press_s[g])
        );
    end

    assign unused_lights_s = ^{main_lights[RED], main_lights[YEL], main_lights[YARROW],
                               cross_lights[RED], cross_lights[YEL], cross_lights[YARROW]};

    // Which lamp satisfies each request; walk-cross and cross-traffic share cross green
    always_comb begin
        srv_s                = 5'b00000;
        srv_s[LEFT_MAIN]     = main_lights[GARROW];
        srv_s[LEFT_CROSS]    = cross_lights[GARROW];
        srv_s[CROSS_TRAFFIC] = cross_lights[GRN];
        srv_s[WALK_MAIN]     = main_lights[GRN];
        srv_s[WALK_CROSS]    = cross_lights[GRN];
    end

    // Per-channel request FSM next state
    always_comb begin
        pend_next_s = 5'b00000;
        for (int i = 0; i < NUM_CH; i++) begin
            state_next_s[i] = state_r[i];
            case (state_r[i])
                IDLE: begin
                    if (press_s[i] && !srv_s[i]) begin
                        state_next_s[i] = PENDING;
                    end else if (press_s[i] && srv_s[i]) begin
                        state_next_s[i] = SERVED;
                    end else begin
                        state_next_s[i] = IDLE;
                    end
                end
                PENDING: begin
                    if (srv_s[i]) begin
                        state_next_s[i] = SERVED;
                    end else begin
                        state_next_s[i] = PENDING;
                    end
                end
                SERVED: begin
                    if (!srv_s[i]) begin
                        state_next_s[i] = IDLE;
                    end else begin
                        state_next_s[i] = SERVED;
                    end
                end
                default: state_next_s[i] = IDLE;
            endcase
            pend_next_s[i] = (state_next_s[i] == PENDING);
        end
    end

    // State registers; outputs taken from next state so count and vector agree
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i] <= IDLE;
            end
            sensors_r       <= 5'b00000;
            pending_count_r <= 3'd0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i] <= state_next_s[i];
            end
            sensors_r       <= pend_next_s;
            pending_count_r <= popcount5(pend_next_s);
        end
    end

    assign sensors       = sensors_r;
    assign pending_count = pending_count_r;

endmodule
